sdram_wb_bridge: RTL
====================

// Module: sdram_wb_bridge
// PURPOSE
//  Bridge between the kernel's Wishbone-style SDRAM port (stb/we/sel/adr/ack) and the sdram_top
//  request/acknowledge controller. Latches address, data and byte lanes, runs one transaction,
//  returns read data and a single-cycle ack, and derives the controller's stretched active-low reset.
//  Sits between topboard's SDRAM interface and sdram_top in every board wrapper.
// PARAMETERS
//  AW           21  word-address width (wb_adr[AW:1]); controller address is {1'b0, adr}
//  RST_STRETCH  4   clk_p cycles sdr_rst_n stays low after synchronised reset release (>=2)
// PORTS
//  clk_p          in   1      bus clock, 100 MHz, rising edge
//  rst            in   1      asynchronous active-high reset
//  wb_stb         in   1      transaction strobe, held until wb_ack seen
//  wb_we          in   1      1=write, 0=read
//  wb_sel         in   2      byte lanes [1]=high, [0]=low (write only)
//  wb_adr         in   AW     word address
//  wb_dat_i       in   16     write data
//  wb_dat_o       out  16     read data, valid while wb_ack=1
//  wb_ack         out  1      transaction done
//  wb_ready       out  1      SDRAM initialised (registered copy of sdr_init_done)
//  sdr_rst_n      out  1      controller reset, active low
//  sdr_wr_req     out  1      write request
//  sdr_rd_req     out  1      read request
//  sdr_wr_ack     in   1      controller write acknowledge (1-cycle pulse)
//  sdr_rd_ack     in   1      controller read acknowledge (1-cycle pulse, sdr_dout valid)
//  sdr_addr       out  AW+1   latched address
//  sdr_din        out  16     latched write data
//  sdr_dout       in   16     controller read data
//  sdr_dqm        out  2      {UDQM,LDQM}; 00 for reads, ~sel for writes
//  sdr_init_done  in   1      controller init complete
// BEHAVIOUR
//  Reset: all outputs 0 except sdr_rst_n=0; state IDLE; wb_dat_o=0.
//  sdr_rst_n: rst passes a 2-flop sync; after sync deasserts, counter runs RST_STRETCH cycles,
//   then sdr_rst_n=1. rst re-assert at any time clears it to 0 immediately (async).
//  FSM IDLE -> REQ -> WAIT -> ACK -> HOLD -> IDLE.
//   IDLE: wb_stb & wb_ready -> latch adr/dat/we, dqm (read: 00, write: ~sel) -> REQ. No stb -> stay.
//   REQ:  sdr_wr_req=we, sdr_rd_req=~we, held through WAIT until the matching ack.
//   WAIT: matching ack -> drop req same edge; read captures sdr_dout into wb_dat_o -> ACK.
//         Non-matching ack ignored.
//   ACK:  wb_ack=1 for exactly one cycle -> HOLD.
//   HOLD: wait for wb_stb=0 -> IDLE (prevents double issue on a held strobe).
//  Latency: stb at edge 0 -> req at edge 1 -> ack at edge N -> wb_ack high during cycle N+1.
//  wb_stb dropping in REQ/WAIT: transaction still completes at the controller; wb_ack is
//   suppressed (wb_ack = ack_reg & wb_stb); state returns to IDLE.
//  sdr_init_done low: IDLE does not accept; in-flight transaction finishes.
//  Address/data/dqm are stable from REQ until the ack edge; sel=00 write still issues, dqm=11.
// CONFIGURATION
//  SDRAM_WPOST_EN defined: write posting. In IDLE, a write latches data and gives wb_ack the next
//   cycle (-> HOLD); the controller write runs in the background (posted flag). A new stb while
//   posted=1 is held off until sdr_wr_ack clears the flag; a read is never acked before an
//   earlier posted write completes. Without the macro, writes ack only after sdr_wr_ack.
// STRUCTURE
//  Package sdram_bridge_pkg: FSM state encoding (localparam ST_IDLE..ST_HOLD), DQM_READ=2'b00.
//  Sub-module sdram_rst_gen (2-flop sync + stretch counter -> sdr_rst_n); remainder is flat FSM.
// TESTING
//  1 rst high 5 cycles then low -> sdr_rst_n rises exactly 2+RST_STRETCH edges after release.
//  2 read adr=0x12345, controller acks 6 cycles later with dout=16'hA5C3 -> wb_dat_o=A5C3,
//    wb_ack one cycle, sdr_dqm=00, sdr_addr=0x012345.
//  3 write sel=2'b10 dat=16'hBEEF -> sdr_dqm=2'b01, sdr_din=BEEF, req held until wr_ack; one ack.
//  4 stb held 10 cycles after ack -> exactly one controller request issued.
//  5 stb dropped in WAIT -> no wb_ack, FSM back in IDLE after controller ack; next read normal.
//  6 SDRAM_WPOST_EN: write then immediate read -> write ack in 2 cycles; read req waits
//    for sdr_wr_ack; rd_req never concurrent with wr_req.

Source files
------------

// File: rtl/sdram_bridge_pkg.sv
// Shared encodings for the Wishbone-to-SDRAM bridge: FSM state codes and the DQM value used on reads.
package sdram_bridge_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_ACK  = 3'd3;
    localparam logic [2:0] ST_HOLD = 3'd4;

    localparam logic [1:0] DQM_READ = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_REQ  = ST_REQ,
        S_WAIT = ST_WAIT,
        S_ACK  = ST_ACK,
        S_HOLD = ST_HOLD
    } state_t;

    // Byte lanes are active-high on the bus but DQM masks are active-high "disable".
    function automatic logic [1:0] wr_dqm(input logic [1:0] sel);
        return ~sel;
    endfunction

endpackage

// File: rtl/sdram_wb_bridge_if.sv
// Bus bundle between the kernel Wishbone port, the bridge and the sdram_top controller.
interface sdram_wb_bridge_if #(parameter int AW = 21) ();
    logic          wb_stb;
    logic          wb_we;
    logic [1:0]    wb_sel;
    logic [AW-1:0] wb_adr;
    logic [15:0]   wb_dat_i;
    logic [15:0]   wb_dat_o;
    logic          wb_ack;
    logic          wb_ready;
    logic          sdr_rst_n;
    logic          sdr_wr_req;
    logic          sdr_rd_req;
    logic          sdr_wr_ack;
    logic          sdr_rd_ack;
    logic [AW:0]   sdr_addr;
    logic [15:0]   sdr_din;
    logic [15:0]   sdr_dout;
    logic [1:0]    sdr_dqm;
    logic          sdr_init_done;

    modport slave (
        input  wb_stb, wb_we, wb_sel, wb_adr, wb_dat_i,
        output wb_dat_o, wb_ack, wb_ready,
        output sdr_rst_n, sdr_wr_req, sdr_rd_req, sdr_addr, sdr_din, sdr_dqm,
        input  sdr_wr_ack, sdr_rd_ack, sdr_dout, sdr_init_done
    );

    modport master (
        output wb_stb, wb_we, wb_sel, wb_adr, wb_dat_i,
        input  wb_dat_o, wb_ack, wb_ready,
        input  sdr_rst_n, sdr_wr_req, sdr_rd_req, sdr_addr, sdr_din, sdr_dqm,
        output sdr_wr_ack, sdr_rd_ack, sdr_dout, sdr_init_done
    );
endinterface

// File: rtl/sdram_rst_gen.sv
// Controller reset generator: 2-flop synchroniser on release, then a RST_STRETCH-cycle down-counter.
module sdram_rst_gen #(
    parameter int RST_STRETCH = 4
) (
    input  logic i_clk_p,
    input  logic i_rst,
    output logic o_rst_n
);
    localparam int CW = $clog2(RST_STRETCH + 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_rst_n;

    // Assertion is asynchronous; release is synchronised, then stretched.
    always_ff @(posedge i_clk_p or posedge i_rst) begin
        if (i_rst) begin
            r_sync  <= 2'b11;
            r_cnt   <= CW'(RST_STRETCH);
            r_rst_n <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], 1'b0};
            if (!r_sync[1] && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == CW'(1))
                    r_rst_n <= 1'b1;
            end
        end
    end

    assign o_rst_n = r_rst_n;

endmodule

// File: rtl/sdram_wb_bridge.sv
// Wishbone-to-sdram_top bridge: one latched transaction at a time with single-cycle wb_ack.
// Optional write posting is enabled by defining SDRAM_WPOST_EN.
//
// state | meaning
// IDLE  | waiting for wb_stb with the controller ready
// REQ   | raise the controller request for the latched transaction
// WAIT  | request held until the matching controller ack
// ACK   | wb_ack high for this one cycle
// HOLD  | wait for wb_stb to drop so a held strobe is not reissued
module sdram_wb_bridge
    import sdram_bridge_pkg::*;
#(
    parameter int AW          = 21,
    parameter int RST_STRETCH = 4
) (
    input  logic             i_clk_p,
    input  logic             i_rst,
    sdram_wb_bridge_if.slave io_bus
);
    state_t      r_state;
    logic        r_ready;
    logic        r_ack;
    logic        r_we;
    logic        r_wr_req;
    logic        r_rd_req;
    logic [AW:0] r_addr;
    logic [15:0] r_din;
    logic [15:0] r_dat_o;
    logic [1:0]  r_dqm;
    logic        w_start;
    logic        w_done;
    logic        w_rst_n;

`ifdef SDRAM_WPOST_EN
    logic        r_posted;
    assign w_start = (r_state == S_IDLE) && io_bus.wb_stb && r_ready && !r_posted;
`else
    assign w_start = (r_state == S_IDLE) && io_bus.wb_stb && r_ready;
`endif
    assign w_done  = r_we ? io_bus.sdr_wr_ack : io_bus.sdr_rd_ack;

    sdram_rst_gen #(.RST_STRETCH(RST_STRETCH)) u_rst_gen (
        .i_clk_p (i_clk_p),
        .i_rst   (i_rst),
        .o_rst_n (w_rst_n)
    );

    always_ff @(posedge i_clk_p or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b0;
            r_ack    <= 1'b0;
            r_we     <= 1'b0;
            r_wr_req <= 1'b0;
            r_rd_req <= 1'b0;
            r_addr   <= '0;
            r_din    <= '0;
            r_dat_o  <= '0;
            r_dqm    <= '0;
`ifdef SDRAM_WPOST_EN
            r_posted <= 1'b0;
`endif
        end else begin
            r_ready <= io_bus.sdr_init_done;
            r_ack   <= 1'b0;
`ifdef SDRAM_WPOST_EN
            // Posted write completes in the background while the FSM serves the bus.
            if (r_posted && io_bus.sdr_wr_ack) begin
                r_posted <= 1'b0;
                r_wr_req <= 1'b0;
            end
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_addr <= {1'b0, io_bus.wb_adr};
                        r_din  <= io_bus.wb_dat_i;
                        r_we   <= io_bus.wb_we;
                        r_dqm  <= io_bus.wb_we ? wr_dqm(io_bus.wb_sel) : DQM_READ;
`ifdef SDRAM_WPOST_EN
                        if (io_bus.wb_we) begin
                            r_wr_req <= 1'b1;
                            r_posted <= 1'b1;
                            r_ack    <= 1'b1;
                            r_state  <= S_ACK;
                        end else begin
                            r_state  <= S_REQ;
                        end
`else
                        r_state <= S_REQ;
`endif
                    end
                end
                S_REQ: begin
                    r_wr_req <= r_we;
                    r_rd_req <= !r_we;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_done) begin
                        r_wr_req <= 1'b0;
                        r_rd_req <= 1'b0;
                        if (!r_we)
                            r_dat_o <= io_bus.sdr_dout;
                        r_ack   <= 1'b1;
                        r_state <= S_ACK;
                    end
                end
                S_ACK: r_state <= S_HOLD;
                S_HOLD: begin
                    if (!io_bus.wb_stb)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // An abandoned strobe still completes at the controller, but the master sees no ack.
    assign io_bus.wb_ack     = r_ack & io_bus.wb_stb;
    assign io_bus.wb_dat_o   = r_dat_o;
    assign io_bus.wb_ready   = r_ready;
    assign io_bus.sdr_rst_n  = w_rst_n;
    assign io_bus.sdr_wr_req = r_wr_req;
    assign io_bus.sdr_rd_req = r_rd_req;
    assign io_bus.sdr_addr   = r_addr;
    assign io_bus.sdr_din    = r_din;
    assign io_bus.sdr_dqm    = r_dqm;

endmodule
